// File: rtl/collision_checker_if.sv
// Signal bundle between the frog/car game logic and the collision checker.
// The game side (master) drives scan requests and object positions; the
// checker (slave) returns its status and the collision report.
interface collision_checker_if;
  logic       frame_tick;
  logic       clear;
  logic [9:0] frog_x;
  logic [2:0] frog_lane;
  logic [9:0] lane0_car0_x;
  logic [9:0] lane1_car0_x;
  logic [9:0] lane2_car0_x;
  logic [9:0] lane3_car0_x;
  logic [9:0] lane4_car0_x;
  logic [9:0] lane4_car1_x;
  logic [9:0] lane5_car0_x;
  logic [9:0] lane0_length;
  logic [9:0] lane1_length;
  logic [9:0] lane2_length;
  logic [9:0] lane3_length;
  logic [9:0] lane4_length;
  logic [9:0] lane5_length;
  logic       busy;
  logic       hit;
  logic [2:0] hit_lane;
  logic       in_grace;
  logic [7:0] hit_count;

  modport master (
    output frame_tick, clear, frog_x, frog_lane,
           lane0_car0_x, lane1_car0_x, lane2_car0_x, lane3_car0_x,
           lane4_car0_x, lane4_car1_x, lane5_car0_x,
           lane0_length, lane1_length, lane2_length, lane3_length,
           lane4_length, lane5_length,
    input  busy, hit, hit_lane, in_grace, hit_count
  );

  modport slave (
    input  frame_tick, clear, frog_x, frog_lane,
           lane0_car0_x, lane1_car0_x, lane2_car0_x, lane3_car0_x,
           lane4_car0_x, lane4_car1_x, lane5_car0_x,
           lane0_length, lane1_length, lane2_length, lane3_length,
           lane4_length, lane5_length,
    output busy, hit, hit_lane, in_grace, hit_count
  );
endinterface

// File: rtl/collision_checker.sv
// Frog-versus-car collision checker. Once per frame it snapshots all object
// positions, walks the seven car entries one per cycle, and reports the
// lowest-index overlapping car in the frog's lane. After a reported hit a
// grace window suppresses the next GRACE_FRAMES accepted scans.
module collision_checker #(
  parameter logic [9:0] FROG_WIDTH   = 10'd32,
  parameter logic [7:0] GRACE_FRAMES = 8'd60
) (
  input  logic                clk,
  input  logic                reset_n,
  collision_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t     state_reg, state_next;
  logic [2:0] idx_reg;
  logic [9:0] frog_x_reg;
  logic [2:0] frog_lane_reg;
  logic [9:0] car_x_reg [7];
  logic [9:0] len_reg   [6];
  logic       match_reg;
  logic       suppress_reg;
  logic [2:0] win_lane_reg;
  logic [7:0] grace_reg;
  logic [7:0] hit_count_reg;
  logic [2:0] hit_lane_reg;

  logic [9:0] car_in [7];
  logic [9:0] len_in [6];
  logic [7:0] entry_match;
  logic [2:0] entry_lane [8];
  logic       accept;
  logic       hit_now;

  assign car_in[0] = bus.lane0_car0_x;
  assign car_in[1] = bus.lane1_car0_x;
  assign car_in[2] = bus.lane2_car0_x;
  assign car_in[3] = bus.lane3_car0_x;
  assign car_in[4] = bus.lane4_car0_x;
  assign car_in[5] = bus.lane4_car1_x;
  assign car_in[6] = bus.lane5_car0_x;
  assign len_in[0] = bus.lane0_length;
  assign len_in[1] = bus.lane1_length;
  assign len_in[2] = bus.lane2_length;
  assign len_in[3] = bus.lane3_length;
  assign len_in[4] = bus.lane4_length;
  assign len_in[5] = bus.lane5_length;

  // Per-entry overlap test on the snapshot; lane 4 owns two entries, so
  // entries 5 and 6 map to lanes 4 and 5. Sums are 11 bits so they never wrap.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_entry
      localparam logic [2:0] LANE = (gi < 5) ? 3'(gi) : 3'(gi - 1);
      logic [10:0] frog_end;
      logic [10:0] car_end;
      assign frog_end          = {1'b0, frog_x_reg} + {1'b0, FROG_WIDTH};
      assign car_end           = {1'b0, car_x_reg[gi]} + {1'b0, len_reg[LANE]};
      assign entry_lane[gi]    = LANE;
      assign entry_match[gi]   = (frog_lane_reg == LANE) &&
                                 ({1'b0, car_x_reg[gi]} < frog_end) &&
                                 ({1'b0, frog_x_reg} < car_end);
    end
  endgenerate
  assign entry_match[7] = 1'b0;
  assign entry_lane[7]  = 3'd0;

  assign accept  = (state_reg == IDLE) && bus.frame_tick && !bus.clear;
  assign hit_now = (state_reg == REPORT) && match_reg && !suppress_reg && !bus.clear;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic; clear always wins and returns to IDLE.
  always_comb begin
    state_next = state_reg;
    if (bus.clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (bus.frame_tick) state_next = SCAN;
        SCAN:    if (idx_reg == 3'd6) state_next = REPORT;
        REPORT:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Snapshot, scan bookkeeping, grace timer and hit report.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_reg       <= '0;
      frog_x_reg    <= '0;
      frog_lane_reg <= '0;
      for (int i = 0; i < 7; i++) car_x_reg[i] <= '0;
      for (int i = 0; i < 6; i++) len_reg[i] <= '0;
      match_reg     <= 1'b0;
      suppress_reg  <= 1'b0;
      win_lane_reg  <= '0;
      grace_reg     <= '0;
      hit_count_reg <= '0;
      hit_lane_reg  <= '0;
    end else if (bus.clear) begin
      grace_reg     <= '0;
      hit_count_reg <= '0;
    end else begin
      if (accept) begin
        frog_x_reg    <= bus.frog_x;
        frog_lane_reg <= bus.frog_lane;
        for (int i = 0; i < 7; i++) car_x_reg[i] <= car_in[i];
        for (int i = 0; i < 6; i++) len_reg[i] <= len_in[i];
        idx_reg       <= '0;
        match_reg     <= 1'b0;
        // The grace state at snapshot time decides whether this scan counts.
        suppress_reg  <= (grace_reg != 8'd0);
        if (grace_reg != 8'd0) grace_reg <= grace_reg - 8'd1;
      end
      if (state_reg == SCAN) begin
        idx_reg <= idx_reg + 3'd1;
        if (!match_reg && entry_match[idx_reg]) begin
          match_reg    <= 1'b1;
          win_lane_reg <= entry_lane[idx_reg];
        end
      end
      if (hit_now) begin
        hit_lane_reg <= win_lane_reg;
        if (hit_count_reg != 8'hFF) hit_count_reg <= hit_count_reg + 8'd1;
        grace_reg    <= GRACE_FRAMES;
      end
    end
  end

  assign bus.busy      = (state_reg == SCAN) || (state_reg == REPORT);
  assign bus.hit       = hit_now;
  assign bus.hit_lane  = hit_lane_reg;
  assign bus.in_grace  = (grace_reg != 8'd0);
  assign bus.hit_count = hit_count_reg;

endmodule

// File: tb/tb_collision_checker.sv
// Bench for collision_checker: hand-built vector table, grace/reset/clear
// sequences, and randomized scans checked against a reference model.
module tb_collision_checker;

  localparam int GRACE = 60;
  localparam int FW    = 32;
  localparam int CAR_LANE [7] = '{0, 1, 2, 3, 4, 4, 5};

  typedef struct packed {
    logic [9:0]       fx;
    logic [2:0]       fl;
    logic [6:0][9:0]  cx;
    logic [5:0][9:0]  ln;
    logic             eh;
    logic [2:0]       el;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  collision_checker_if bif();
  collision_checker dut (.clk(clk), .reset_n(reset_n), .bus(bif.slave));

  int n_chk = 0;
  int n_fail = 0;
  int hit_total = 0;
  int m_grace = 0;
  int m_count = 0;
  int m_lane = 0;

  always @(negedge clk) if (bif.hit === 1'b1) hit_total++;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(int fx, int fl, int ci, int cx, int ci2, int cx2,
                              int li, int lv, bit eh, int el);
    vec_t v;
    v.fx = 10'(fx);
    v.fl = 3'(fl);
    for (int e = 0; e < 7; e++) v.cx[e] = 10'd900;
    for (int l = 0; l < 6; l++) v.ln[l] = 10'd96;
    if (ci >= 0)  v.cx[ci]  = 10'(cx);
    if (ci2 >= 0) v.cx[ci2] = 10'(cx2);
    if (li >= 0)  v.ln[li]  = 10'(lv);
    v.eh = eh;
    v.el = 3'(el);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.fl = 3'($urandom_range(0, 7));
    v.fx = 10'($urandom_range(0, 1023));
    for (int e = 0; e < 7; e++)
      if ($urandom_range(0, 1) == 1) v.cx[e] = 10'(int'(v.fx) + $urandom_range(0, 200) - 100);
      else                          v.cx[e] = 10'($urandom_range(0, 1023));
    for (int l = 0; l < 6; l++) v.ln[l] = 10'($urandom_range(0, 255));
    v.eh = 1'b0;
    v.el = 3'd0;
    return v;
  endfunction

  // Reference: first car in table order sitting in the frog's lane whose
  // half-open span [cx, cx+len) intersects [fx, fx+FW).
  task automatic ref_find(input vec_t v, output bit f, output int lane);
    int fx, cx, ln;
    f = 1'b0;
    lane = 0;
    fx = int'(v.fx);
    for (int e = 0; e < 7; e++) begin
      cx = int'(v.cx[e]);
      ln = int'(v.ln[CAR_LANE[e]]);
      if (!f && CAR_LANE[e] == int'(v.fl) && cx < fx + FW && fx < cx + ln) begin
        f = 1'b1;
        lane = CAR_LANE[e];
      end
    end
  endtask

  task automatic drive(input vec_t v);
    bif.frog_x       = v.fx;
    bif.frog_lane    = v.fl;
    bif.lane0_car0_x = v.cx[0];
    bif.lane1_car0_x = v.cx[1];
    bif.lane2_car0_x = v.cx[2];
    bif.lane3_car0_x = v.cx[3];
    bif.lane4_car0_x = v.cx[4];
    bif.lane4_car1_x = v.cx[5];
    bif.lane5_car0_x = v.cx[6];
    bif.lane0_length = v.ln[0];
    bif.lane1_length = v.ln[1];
    bif.lane2_length = v.ln[2];
    bif.lane3_length = v.ln[3];
    bif.lane4_length = v.ln[4];
    bif.lane5_length = v.ln[5];
  endtask

  task automatic do_clear();
    bif.clear = 1'b1;
    @(posedge clk); #1;
    bif.clear = 1'b0;
    m_grace = 0;
    m_count = 0;
  endtask

  // Runs one scan, scrambling the live inputs while it is in flight.
  task automatic scan_and_check(input string nm, input vec_t v,
                                output int pulses, output int lane_o);
    bit f, sup, exp_hit;
    int fl, hk, berr;
    ref_find(v, f, fl);
    sup = (m_grace != 0);
    if (sup) m_grace--;
    exp_hit = f && !sup;
    if (exp_hit) begin
      m_lane = fl;
      if (m_count < 255) m_count++;
      m_grace = GRACE;
    end
    drive(v);
    bif.frame_tick = 1'b1;
    @(posedge clk); #1;
    bif.frame_tick = 1'b0;
    drive(rand_vec());
    pulses = 0; hk = 0; berr = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bif.hit) begin pulses++; hk = k; end
      if (bif.busy !== (k <= 8)) berr++;
    end
    @(posedge clk); #1;
    chk({nm, " hit_pulses"}, pulses, int'(exp_hit));
    if (exp_hit) chk({nm, " hit_cycle"}, hk, 8);
    chk({nm, " busy_window_errors"}, berr, 0);
    chk({nm, " hit_lane"}, int'(bif.hit_lane), m_lane);
    chk({nm, " hit_count"}, int'(bif.hit_count), m_count);
    chk({nm, " in_grace"}, int'(bif.in_grace), int'(m_grace != 0));
    lane_o = int'(bif.hit_lane);
    $display("scan %s: frog_x=%0d lane=%0d pulses=%0d hit_lane=%0d count=%0d",
             nm, v.fx, v.fl, pulses, lane_o, bif.hit_count);
  endtask

  vec_t tbl [11];

  initial begin
    int p, l, h0;
    vec_t v;

    tbl[0]  = mk(200, 2, 2, 150, -1, 0, -1, 0, 1'b1, 2);
    tbl[1]  = mk(200, 2, 2, 232, -1, 0, -1, 0, 1'b0, 0);
    tbl[2]  = mk(200, 2, 2, 104, -1, 0, -1, 0, 1'b0, 0);
    tbl[3]  = mk(200, 2, 2, 231, -1, 0, -1, 0, 1'b1, 2);
    tbl[4]  = mk(200, 4, 4, 300, 5, 190, 4, 64, 1'b1, 4);
    tbl[5]  = mk(200, 7, 4, 300, 5, 190, 4, 64, 1'b0, 0);
    tbl[6]  = mk(200, 5, 6, 200, -1, 0, 5, 1, 1'b1, 5);
    tbl[7]  = mk(1000, 0, 0, 1000, -1, 0, 0, 1023, 1'b1, 0);
    tbl[8]  = mk(200, 3, 3, 199, -1, 0, 3, 1, 1'b0, 0);
    tbl[9]  = mk(0, 1, 1, 0, -1, 0, 1, 0, 1'b0, 0);
    tbl[10] = mk(200, 4, 4, 200, 5, 200, -1, 0, 1'b1, 4);

    bif.frame_tick = 1'b0;
    bif.clear = 1'b0;
    drive(tbl[0]);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", int'(bif.busy), 0);
    chk("reset hit", int'(bif.hit), 0);
    chk("reset hit_lane", int'(bif.hit_lane), 0);
    chk("reset in_grace", int'(bif.in_grace), 0);
    chk("reset hit_count", int'(bif.hit_count), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table of single-scan vectors, each from a cleared state
    for (int i = 0; i < 11; i++) begin
      do_clear();
      scan_and_check($sformatf("vec%0d", i), tbl[i], p, l);
      chk($sformatf("vec%0d table_hit", i), p, int'(tbl[i].eh));
      if (tbl[i].eh) chk($sformatf("vec%0d table_lane", i), l, int'(tbl[i].el));
    end

    // Repeated frame_tick while busy is ignored
    do_clear();
    drive(tbl[0]);
    h0 = hit_total;
    bif.frame_tick = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    bif.frame_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("held_tick hit_pulses", hit_total - h0, 1);
    chk("held_tick hit_count", int'(bif.hit_count), 1);
    chk("held_tick busy", int'(bif.busy), 0);
    $display("held_tick: pulses=%0d count=%0d", hit_total - h0, bif.hit_count);

    // Clear and frame_tick together
    bif.clear = 1'b1;
    bif.frame_tick = 1'b1;
    @(posedge clk); #1;
    bif.clear = 1'b0;
    bif.frame_tick = 1'b0;
    m_grace = 0;
    m_count = 0;
    @(negedge clk);
    chk("clear_tick busy", int'(bif.busy), 0);
    chk("clear_tick hit_count", int'(bif.hit_count), 0);
    chk("clear_tick in_grace", int'(bif.in_grace), 0);
    @(posedge clk); #1;
    $display("clear_tick: busy=%0d count=%0d", bif.busy, bif.hit_count);

    // Grace window: hit, 60 suppressed scans, then a hit again
    scan_and_check("grace_first", tbl[0], p, l);
    for (int i = 0; i < 61; i++)
      scan_and_check($sformatf("grace%0d", i), tbl[0], p, l);
    chk("grace final hit_count", int'(bif.hit_count), 2);

    // Asynchronous reset in the middle of a scan
    drive(tbl[0]);
    bif.frame_tick = 1'b1;
    @(posedge clk); #1;
    bif.frame_tick = 1'b0;
    h0 = hit_total;
    repeat (4) @(negedge clk);
    chk("midreset busy_before", int'(bif.busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset busy", int'(bif.busy), 0);
    chk("midreset hit", int'(bif.hit), 0);
    chk("midreset hit_lane", int'(bif.hit_lane), 0);
    chk("midreset in_grace", int'(bif.in_grace), 0);
    chk("midreset hit_count", int'(bif.hit_count), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midreset no_pulse", hit_total - h0, 0);
    $display("midreset: pulses=%0d count=%0d", hit_total - h0, bif.hit_count);
    m_grace = 0;
    m_count = 0;
    m_lane = 0;
    scan_and_check("after_reset", tbl[0], p, l);

    // Randomized scans against the reference model
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 2) == 0) do_clear();
      v = rand_vec();
      scan_and_check($sformatf("rnd%0d", i), v, p, l);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
